// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch and the load/store path
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   flush                  branch redirect, squashes fetch reads in flight
//   fetch_req/addr/gnt     fetch read request, combinational grant
//   fetch_rsp_vld/data     registered instruction response
//   data_req/we/addr/wdata/be/gnt  load/store request, combinational grant
//   data_rsp_vld/data      registered load response
//   ram_en/we/addr/wdata/be  registered RAM command; ram_rdata returns RD_LAT cycles after ram_en
//   Optional macro MEMARB_ROUND_ROBIN_EN: alternate on conflict instead of data priority with starvation guard
module mem_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rsp_vld,
  output logic [XLEN-1:0]   fetch_rsp_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [XLEN-1:0]   data_wdata,
  input  logic [XLEN/8-1:0] data_be,
  output logic              data_gnt,
  output logic              data_rsp_vld,
  output logic [XLEN-1:0]   data_rsp_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  output logic [XLEN/8-1:0] ram_be,
  input  logic [XLEN-1:0]   ram_rdata
);
  logic            fetch_win;
  logic [RD_LAT:0] tag_vld;
  logic [RD_LAT:0] tag_fetch;
`ifdef MEMARB_ROUND_ROBIN_EN
  logic last_fetch;
  assign fetch_win = !data_req || !last_fetch;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_fetch <= 1'b0;
    else if (fetch_gnt || data_gnt) last_fetch <= fetch_gnt;
`else
  logic [3:0] wait_cnt;
  assign fetch_win = !data_req || wait_cnt >= 4'(MAX_WAIT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= '0;
    else wait_cnt <= (fetch_req && !fetch_gnt) ? ((wait_cnt == 4'hf) ? wait_cnt : wait_cnt + 4'd1) : '0;
`endif
  assign fetch_gnt = fetch_req && !flush && fetch_win;
  assign data_gnt  = data_req && !fetch_gnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ram_en         <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_be         <= '0;
      tag_vld        <= '0;
      tag_fetch      <= '0;
      fetch_rsp_vld  <= 1'b0;
      fetch_rsp_data <= '0;
      data_rsp_vld   <= 1'b0;
      data_rsp_data  <= '0;
    end else begin
      ram_en         <= fetch_gnt || data_gnt;
      ram_we         <= data_gnt && data_we;
      ram_addr       <= fetch_gnt ? fetch_addr : data_addr;
      ram_wdata      <= data_wdata;
      ram_be         <= (data_gnt && data_we) ? data_be : '1;
      // flush kills every fetch-owned tag as it shifts; a fetch is never pushed while flush is high
      tag_vld        <= {tag_vld[RD_LAT-1:0] & ~(tag_fetch[RD_LAT-1:0] & {RD_LAT{flush}}),
                         fetch_gnt || (data_gnt && !data_we)};
      tag_fetch      <= {tag_fetch[RD_LAT-1:0], fetch_gnt};
      // the last stage lines up with ram_rdata; it is squashed too if flush hits this cycle
      fetch_rsp_vld  <= tag_vld[RD_LAT] && tag_fetch[RD_LAT] && !flush;
      data_rsp_vld   <= tag_vld[RD_LAT] && !tag_fetch[RD_LAT];
      if (tag_vld[RD_LAT] && tag_fetch[RD_LAT] && !flush) fetch_rsp_data <= ram_rdata;
      if (tag_vld[RD_LAT] && !tag_fetch[RD_LAT]) data_rsp_data <= ram_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven and directed checks of mem_port_arbiter with a behavioural RAM
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [31:0] fetch_addr = '0, data_addr = '0, data_wdata = '0, ram_rdata = '0;
  logic [3:0]  data_be = 4'hf;
  logic        fetch_gnt, fetch_rsp_vld, data_gnt, data_rsp_vld, ram_en, ram_we;
  logic [31:0] fetch_rsp_data, data_rsp_data, ram_addr, ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] mem [0:255];
  int          errors = 0, checks = 0;
  logic [9:0]  pat;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rsp_vld(fetch_rsp_vld), .fetch_rsp_data(fetch_rsp_data),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be), .data_gnt(data_gnt),
    .data_rsp_vld(data_rsp_vld), .data_rsp_data(data_rsp_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM with one cycle of read latency
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else ram_rdata <= mem[ram_addr[9:2]];
    end

  typedef struct {
    logic fr; logic [31:0] fa; logic dr; logic dw; logic [31:0] da; logic [31:0] dd; logic fl;
    logic efg; logic edg; logic een; logic ewe; logic [31:0] eaddr; logic efv; logic edv; logic [31:0] erd;
  } vec_t;
  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0; flush = 1'b0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 32'h00500093;
    mem[12] = 32'h00000013;
    //          fr    fa        dr    dw    da         dd            fl    fg    dg    en    we    addr       fv    dv    rsp data
    vecs[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10,  1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h00500093};
    vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h24, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20,  1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 32'h28, 1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h24,  1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hDEADBEEF};
    vecs[16] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};

    // reset state, then idle
    @(negedge clk);
    chk("rst ram_en", ram_en, 0);
    chk("rst fetch_rsp_vld", fetch_rsp_vld, 0);
    chk("rst data_rsp_vld", data_rsp_vld, 0);
    chk("rst ram_addr", ram_addr, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d ram_en", i), ram_en, 0);
      next_cycle();
    end

    // single fetch, store-then-load, flush with a data load in flight
    for (int i = 0; i < 17; i++) begin
      fetch_req = vecs[i].fr; fetch_addr = vecs[i].fa; data_req = vecs[i].dr; data_we = vecs[i].dw;
      data_addr = vecs[i].da; data_wdata = vecs[i].dd; flush = vecs[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d fetch_gnt", i), fetch_gnt, vecs[i].efg);
      chk($sformatf("v%0d data_gnt", i), data_gnt, vecs[i].edg);
      chk($sformatf("v%0d ram_en", i), ram_en, vecs[i].een);
      if (vecs[i].een) begin
        chk($sformatf("v%0d ram_addr", i), ram_addr, vecs[i].eaddr);
        chk($sformatf("v%0d ram_we", i), ram_we, vecs[i].ewe);
      end
      chk($sformatf("v%0d fetch_rsp_vld", i), fetch_rsp_vld, vecs[i].efv);
      chk($sformatf("v%0d data_rsp_vld", i), data_rsp_vld, vecs[i].edv);
      if (vecs[i].efv) chk($sformatf("v%0d fetch_rsp_data", i), fetch_rsp_data, vecs[i].erd);
      if (vecs[i].edv) chk($sformatf("v%0d data_rsp_data", i), data_rsp_data, vecs[i].erd);
      next_cycle();
    end
    idle();

    // both requesting continuously; bit i set = fetch wins in cycle i
`ifdef MEMARB_ROUND_ROBIN_EN
    pat = 10'b0101010101;
`else
    pat = 10'b1000010000;
`endif
    for (int i = 0; i < 10; i++) begin
      fetch_req = 1'b1; fetch_addr = 32'h30; data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100;
      @(negedge clk);
      chk($sformatf("arb%0d fetch_gnt", i), fetch_gnt, pat[i]);
      chk($sformatf("arb%0d data_gnt", i), data_gnt, !pat[i]);
      next_cycle();
    end
    idle();
    for (int i = 0; i < 6; i++) next_cycle();

    // reset with reads in flight
    fetch_req = 1'b1; fetch_addr = 32'h10;
    @(negedge clk);
    chk("rf fetch_gnt", fetch_gnt, 1);
    next_cycle();
    idle();
    data_req = 1'b1; data_addr = 32'h100;
    next_cycle();
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk("rf ram_en", ram_en, 0);
    chk("rf ram_addr", ram_addr, 0);
    chk("rf fetch_rsp_data", fetch_rsp_data, 0);
    chk("rf data_rsp_data", data_rsp_data, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("post%0d fetch_rsp_vld", i), fetch_rsp_vld, 0);
      chk($sformatf("post%0d data_rsp_vld", i), data_rsp_vld, 0);
      chk($sformatf("post%0d ram_en", i), ram_en, 0);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data RAM between the fetch stage (instruction reads) and the ALU load/store path (data reads and writes).
- Accepts at most one request per cycle, registers the winning command to the RAM, and tracks in-flight reads in a tag pipeline so each read response returns to the requester that issued it.
- Squashes in-flight fetch responses when a branch redirect flushes the front end.

Parameters:
cXLEN, 32, data width in bits.
cAddrW, 32, byte address width.
cRdLat, 1, RAM read latency in cycles, from oRamEn sampled to iRamRData valid; legal range 1..4.
cMaxWait, 4, consecutive lost-arbitration cycles before fetch is forced to win; legal range 1..15.

Ports:
iClk  in  1  clock, rising edge.
iRst  in  1  reset, asynchronous, active-low.
iFlush  in  1  branch redirect; squashes fetch reads in flight.
iFetchReq  in  1  fetch read request; held until granted.
iFetchAddr  in  cAddrW  fetch byte address, word aligned.
oFetchGnt  out  1  fetch request accepted this cycle (combinational).
oFetchRspVld  out  1  fetch read data valid (registered).
oFetchRspData  out  cXLEN  instruction word.
iDataReq  in  1  load/store request; held until granted.
iDataWe  in  1  1 = store, 0 = load.
iDataAddr  in  cAddrW  data byte address.
iDataWData  in  cXLEN  store data.
iDataBe  in  cXLEN/8  store byte enables.
oDataGnt  out  1  data request accepted this cycle (combinational).
oDataRspVld  out  1  load data valid (registered).
oDataRspData  out  cXLEN  load data.
oRamEn  out  1  RAM access strobe (registered).
oRamWe  out  1  RAM write enable (registered).
oRamAddr  out  cAddrW  RAM address (registered).
oRamWData  out  cXLEN  RAM write data (registered).
oRamBe  out  cXLEN/8  RAM byte enables; all ones for reads.
iRamRData  in  cXLEN  RAM read data, valid cRdLat cycles after oRamEn.

Behaviour:
- Reset (iRst=0, asynchronous): every registered output goes to 0, the tag pipeline clears, the wait counter clears, and lastOwner = DATA. Reads in flight when reset asserts are lost and produce no response.
- Arbitration (combinational, cycle N):
  - Only one requester high: it wins.
  - Both high: data wins, unless waitCnt >= cMaxWait, in which case fetch wins.
  - Fetch cannot be granted in a cycle where iFlush=1; data is unaffected by iFlush.
- waitCnt: increments, saturating at 15, each cycle iFetchReq=1 and oFetchGnt=0. Clears when fetch is granted or iFetchReq=0.
- Command: the winner's command is registered onto the oRam* outputs and is visible in cycle N+1. oRamEn=0 in any cycle that follows a cycle with no grant. Throughput is one access per cycle, with back-to-back grants allowed.
- Tag pipeline: cRdLat+1 stages, each holding {vld, owner}. A read pushes {1, owner}; a write pushes {0, x}.
- Response: when the tag reaching the last stage has vld=1, the design registers iRamRData into that owner's RspData and pulses that owner's RspVld. Load/fetch latency is cRdLat+2 cycles from the grant cycle. Stores produce no response.
- Ordering: responses return in grant order. RAM accesses are serialized, so a store granted in cycle N is visible to a load granted in cycle N+1.
- Flush: when iFlush=1, every in-flight tag with owner=FETCH is cleared to vld=0, including the entry pushed in that same cycle. Data tags are untouched. oFetchRspVld stays 0 for each squashed read.
- RspData outputs hold their last value when RspVld=0.
- Address alignment is not checked; fetch addresses are passed to the RAM unmodified.

Optional Feature:
- Macro MEMARB_ROUND_ROBIN_EN.
- Defined: on a conflict, the requester that is not lastOwner wins. lastOwner updates on every grant. waitCnt and cMaxWait are ignored, and the counter logic is compiled out.
- Undefined: data-priority arbitration with the cMaxWait starvation guard, as described above.

Test Plan:
- Reset then idle: all outputs 0; oRamEn stays 0 for 10 cycles.
- Single fetch read to 0x10 with RAM word 0x00500093, cRdLat=1: oFetchGnt=1 in cycle 0, oRamEn=1 with oRamAddr=0x10 in cycle 1, oFetchRspVld=1 with data 0x00500093 in cycle 3.
- Both requesting continuously, cMaxWait=4: data is granted cycles 0-3, fetch in cycle 4, data in cycles 5-8, fetch in cycle 9. With MEMARB_ROUND_ROBIN_EN defined, grants alternate F,D,F,D starting with F.
- Store 0xDEADBEEF with Be=0xF to 0x100 in cycle 0, load from 0x100 in cycle 1: oDataRspVld=1 with 0xDEADBEEF in cycle 4; no response pulse for the store.
- Fetch reads granted in cycles 0 and 1, iFlush=1 in cycle 2, interleaved data load in flight: no oFetchRspVld for either fetch, the data response still arrives on time, and fetch is not granted in cycle 2.
- iRst asserted in cycle 2 with reads in flight, released in cycle 4: outputs go to 0 immediately, and no stale RspVld appears after release.
